// File: rtl/maria_line_writer.sv
// MARIA DMA line writer: a 2-entry graphics-byte FIFO feeding a two-lane pixel emitter.
// Supports the 160A mode (4 pixels over 2 cycles) and the 160B mode (2 pixels in 1 cycle).
module maria_line_writer (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic [7:0] DataB,
    input  logic       palette_w,
    input  logic       wm_w,
    input  logic       input_w,
    input  logic       pixels_w,
    input  logic       line_clear,
    input  logic       kangaroo,
    output logic       px0_we,
    output logic       px1_we,
    output logic [7:0] px0_addr,
    output logic [7:0] px1_addr,
    output logic [4:0] px0_data,
    output logic [4:0] px1_data,
    output logic       busy,
    output logic       overflow
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StEmitA = 2'd1;
    localparam logic [1:0] StEmitB = 2'd2;

    // Entry layout: {byte[19:12], wm[11], palette[10:8], hpos[7:0]}
    logic [19:0] fifo_q [2];
    logic [19:0] fifo_d [2];
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]  state_q, state_d;
    logic        sub_q, sub_d;
    logic [7:0]  cur_byte_q, cur_byte_d, cur_hpos_q, cur_hpos_d;
    logic [2:0]  cur_pal_q, cur_pal_d;
    logic [2:0]  palette_q, palette_d;
    logic        wm_q, wm_d;
    logic [7:0]  push_hpos_q, push_hpos_d;
    logic        overflow_q, overflow_d;
    logic        we0_q, we0_d, we1_q, we1_d;
    logic [7:0]  addr0_q, addr0_d, addr1_q, addr1_d;
    logic [4:0]  data0_q, data0_d, data1_q, data1_d;

    logic [7:0]  start_hpos;
    logic [19:0] entry_in, ld_entry;
    logic        push_req, push_ok, rel, load, emit;
    logic [1:0]  c0, c1;

    always_comb begin
        palette_d   = palette_w ? DataB[7:5] : palette_q;
        wm_d        = wm_w ? DataB[7] : wm_q;
        start_hpos  = input_w ? DataB : push_hpos_q;
        push_req    = pixels_w && !line_clear;
        push_hpos_d = start_hpos;
        if (pixels_w && !line_clear) begin
            push_hpos_d = start_hpos + (wm_d ? 8'd2 : 8'd4);
        end
        entry_in = {DataB, wm_d, palette_d, start_hpos};

        // The head entry stays in the FIFO until its last emission cycle, then is released.
        rel     = (state_q == StEmitA && sub_q) || (state_q == StEmitB);
        push_ok = push_req && (count_q != 2'd2 || rel);

        state_d    = state_q;
        sub_d      = 1'b0;
        cur_byte_d = cur_byte_q;
        cur_pal_d  = cur_pal_q;
        cur_hpos_d = cur_hpos_q;
        load       = 1'b0;
        ld_entry   = fifo_q[rd_ptr_q];
        unique case (state_q)
            StIdle: load = (count_q != 2'd0);
            StEmitA: begin
                if (!sub_q) begin
                    sub_d = 1'b1;
                end else if (count_q == 2'd2) begin
                    load     = 1'b1;
                    ld_entry = fifo_q[~rd_ptr_q];
                end else begin
                    state_d = StIdle;
                end
            end
            StEmitB: begin
                if (count_q == 2'd2) begin
                    load     = 1'b1;
                    ld_entry = fifo_q[~rd_ptr_q];
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            cur_byte_d = ld_entry[19:12];
            cur_pal_d  = ld_entry[10:8];
            cur_hpos_d = ld_entry[7:0];
            state_d    = ld_entry[11] ? StEmitB : StEmitA;
            sub_d      = 1'b0;
        end

        fifo_d = fifo_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = entry_in;
        end
        rd_ptr_d = rd_ptr_q ^ rel;
        wr_ptr_d = wr_ptr_q ^ push_ok;
        count_d  = count_q;
        if (push_ok && !rel) begin
            count_d = count_q + 2'd1;
        end else if (!push_ok && rel) begin
            count_d = count_q - 2'd1;
        end
        overflow_d = overflow_q || (push_req && count_q == 2'd2 && !rel);

        if (line_clear) begin
            state_d    = StIdle;
            sub_d      = 1'b0;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        addr0_d = cur_hpos_q + {6'd0, sub_q, 1'b0};
        addr1_d = addr0_d + 8'd1;
        if (state_q == StEmitB) begin
            c0      = cur_byte_q[7:6];
            c1      = cur_byte_q[5:4];
            data0_d = {cur_pal_q[2], cur_byte_q[3:2], c0};
            data1_d = {cur_pal_q[2], cur_byte_q[1:0], c1};
        end else begin
            c0      = sub_q ? cur_byte_q[3:2] : cur_byte_q[7:6];
            c1      = sub_q ? cur_byte_q[1:0] : cur_byte_q[5:4];
            data0_d = {cur_pal_q, c0};
            data1_d = {cur_pal_q, c1};
        end
        emit  = (state_q != StIdle) && !line_clear;
        we0_d = emit && (c0 != 2'b00 || kangaroo) && (addr0_d < 8'd160);
        we1_d = emit && (c1 != 2'b00 || kangaroo) && (addr1_d < 8'd160);
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            state_q     <= StIdle;
            sub_q       <= 1'b0;
            cur_byte_q  <= 8'd0;
            cur_pal_q   <= 3'd0;
            cur_hpos_q  <= 8'd0;
            palette_q   <= 3'd0;
            wm_q        <= 1'b0;
            push_hpos_q <= 8'd0;
            overflow_q  <= 1'b0;
            we0_q       <= 1'b0;
            we1_q       <= 1'b0;
            addr0_q     <= 8'd0;
            addr1_q     <= 8'd0;
            data0_q     <= 5'd0;
            data1_q     <= 5'd0;
        end else begin
            fifo_q      <= fifo_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            state_q     <= state_d;
            sub_q       <= sub_d;
            cur_byte_q  <= cur_byte_d;
            cur_pal_q   <= cur_pal_d;
            cur_hpos_q  <= cur_hpos_d;
            palette_q   <= palette_d;
            wm_q        <= wm_d;
            push_hpos_q <= push_hpos_d;
            overflow_q  <= overflow_d;
            we0_q       <= we0_d;
            we1_q       <= we1_d;
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
        end
    end

    assign px0_we   = we0_q;
    assign px1_we   = we1_q;
    assign px0_addr = addr0_q;
    assign px1_addr = addr1_q;
    assign px0_data = data0_q;
    assign px1_data = data1_q;
    assign busy     = (count_q != 2'd0) || (state_q != StIdle);
    assign overflow = overflow_q;

endmodule

// File: doc/maria_line_writer.md
MARIA_LINE_WRITER -- requirements
Module: maria_line_writer

Interface
REQ-001 sysclk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 DataB  input  8  DMA data bus; sampled only in cycles where a strobe is high.
REQ-004 palette_w  input  1  header strobe: palette <= DataB[7:5].
REQ-005 wm_w  input  1  header strobe: write mode wm <= DataB[7].
REQ-006 input_w  input  1  header strobe: object horizontal start hpos <= DataB.
REQ-007 pixels_w  input  1  graphics byte on DataB; push to FIFO.
REQ-008 line_clear  input  1  start of new line: flush FIFO, abort emission.
REQ-009 kangaroo  input  1  1 = transparent pixels are also written.
REQ-010 px0_we, px1_we  output  1 each  lane write enables, registered.
REQ-011 px0_addr, px1_addr  output  8 each  line-RAM pixel index (0..159), registered.
REQ-012 px0_data, px1_data  output  5 each  {palette[2:0], color[1:0]}, registered.
REQ-013 busy  output  1  FIFO non-empty or emission in progress.
REQ-014 overflow  output  1  sticky; set on push into full FIFO with no pop.

Function
REQ-015 Header latches (palette, wm, push_hpos) SHALL update on the rising edge where their strobe is high; multiple strobes in one cycle all take effect.
REQ-016 On pixels_w, one entry {byte, wm, palette, push_hpos} SHALL be pushed; push_hpos then advances by 4 (wm=0) or 2 (wm=1), modulo 256.
REQ-017 If input_w and pixels_w occur in the same cycle, the pushed entry SHALL use the new DataB as start and push_hpos SHALL become DataB+4 or DataB+2.
REQ-018 FIFO depth 2 entries; simultaneous push and pop when full SHALL succeed without overflow; push when full without pop SHALL drop the byte and set overflow.
REQ-019 FSM states IDLE, EMIT_A, EMIT_B; reset/line_clear -> IDLE.
REQ-020 IDLE: if FIFO non-empty, pop head; wm=0 -> EMIT_A, wm=1 -> EMIT_B.
REQ-021 EMIT_A (160A, cycle 1): lane0 = byte[7:6] at hpos, lane1 = byte[5:4] at hpos+1; next EMIT_A2 sub-phase emits byte[3:2] at hpos+2, byte[1:0] at hpos+3; then pop next entry or IDLE (the sub-phase is a 1-bit counter within EMIT_A).
REQ-022 EMIT_B (160B, 1 cycle): lane0 color=byte[7:6], palette={pal[2],byte[3:2]} at hpos; lane1 color=byte[5:4], palette={pal[2],byte[1:0]} at hpos+1.
REQ-023 Back-to-back entries SHALL be emitted without idle cycles; emission of a popped entry begins the cycle after pop.
REQ-024 Latency: pixels_w sampled at edge N into empty FIFO, idle FSM -> first lane writes visible after edge N+2.
REQ-025 Lane we SHALL be 0 when color==2'b00 and kangaroo=0, or when pixel address >= 160 (addresses are computed mod 256).
REQ-026 Outputs SHALL hold we=0 in every cycle without an emitted pixel; addr/data then are don't-care.
REQ-027 line_clear SHALL take priority over pixels_w in the same cycle (byte discarded); header latches unaffected; overflow cleared.
REQ-028 busy SHALL be 1 while FIFO count > 0 or FSM != IDLE.

Reset
REQ-029 reset_n low SHALL asynchronously force: FSM IDLE, FIFO empty, all we=0, addr=0, data=0, palette=0, wm=0, push_hpos=0, busy=0, overflow=0.
REQ-030 Deassertion mid-line SHALL resume from that clean state; no partial pixels emitted.

Verification
REQ-031 palette_w DataB=0xA0, input_w 0x10, pixels_w 0xE4 (wm=0) -> (0x10 pal5 c3),(0x11 c2),(0x12 c1); 0x13 c0 suppressed.
REQ-032 Same with kangaroo=1 -> 0x13 written with data {101,00}.
REQ-033 wm_w DataB=0x80, palette 0x80, input 0x9E, pixels 0x5B -> 0x9E data {1,10,01}, 0x9F data {1,11,01}; next byte targets 0xA0 (>=160) -> no writes.
REQ-034 Three pixels_w on consecutive cycles, wm=0 -> third push sets overflow; first two bytes emitted in 4 consecutive cycles.
REQ-035 pixels_w every 3 cycles for 20 bytes, wm=0 -> no overflow, 80 contiguous addresses written in order.
REQ-036 reset_n pulsed low during EMIT_A second half -> all we drop immediately, busy=0, FIFO empty.
